// File: rtl/pift_pkg.sv
// ============================================================================
// Module   : pift_pkg
// Brief    : Shared types and helpers for PIFT taint-tracking cells.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pift_pkg;

    typedef enum logic {
        SWEEP_IDLE = 1'b0,
        SWEEP_RUN  = 1'b1
    } pift_sweep_state_t;

    // True when addr falls inside [offset, offset+size).
    function automatic logic pift_addr_in_range(
        input logic [31:0] addr,
        input logic [31:0] offset,
        input logic [31:0] size
    );
        return (addr >= offset) && ((addr - offset) < size);
    endfunction

endpackage

`default_nettype wire

// File: rtl/taintcell_memx_sweep.sv
// ============================================================================
// Module   : taintcell_memx_sweep
// Brief    : Background clear sweeper; walks word indices 0..SIZE-1 once per request.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module taintcell_memx_sweep #(
    parameter int SIZE  = 4,
    parameter int ABITS = 2
) (
    input  logic             pos_clk,
    input  logic             pos_arst,
    input  logic             clr_req,
    output logic             clr_busy,
    output logic             clr_stb,
    output logic [ABITS-1:0] clr_idx
);
    import pift_pkg::*;

    localparam logic [ABITS-1:0] c_last = ABITS'(SIZE - 1);
    localparam logic [ABITS-1:0] c_one  = ABITS'(1);

    pift_sweep_state_t r_state;
    pift_sweep_state_t w_state_nxt;
    logic [ABITS-1:0]  r_idx;
    logic [ABITS-1:0]  w_idx_nxt;

    always_ff @(posedge pos_clk or posedge pos_arst) begin
        if (pos_arst) begin
            r_state <= SWEEP_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // A request seen while sweeping is simply dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            SWEEP_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = SWEEP_RUN;
                    w_idx_nxt   = '0;
                end
            end
            SWEEP_RUN: begin
                w_idx_nxt = r_idx + c_one;
                if (r_idx == c_last) begin
                    w_state_nxt = SWEEP_IDLE;
                    w_idx_nxt   = '0;
                end
            end
        endcase
    end

    assign clr_busy = (r_state == SWEEP_RUN);
    assign clr_stb  = (r_state == SWEEP_RUN);
    assign clr_idx  = r_idx;

endmodule

`default_nettype wire

// File: rtl/taintcell_memx.sv
// ============================================================================
// Module   : taintcell_memx
// Brief    : Multi-port shadow-taint memory with sweeper, transparency and
//            optional tainted-word counter (enabled by PIFT_TAINT_SUM_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module taintcell_memx #(
    parameter int                     SIZE           = 4,
    parameter int                     OFFSET         = 0,
    parameter int                     ABITS          = 2,
    parameter int                     WIDTH          = 8,
    parameter int                     RD_PORTS       = 1,
    parameter int                     WR_PORTS       = 1,
    parameter logic [RD_PORTS-1:0]    RD_TRANSPARENT = '0
) (
    input  logic                          pos_clk,
    input  logic                          pos_arst,
    input  logic [RD_PORTS-1:0]           rd_en,
    input  logic [RD_PORTS-1:0]           rd_en_taint,
    input  logic [RD_PORTS*ABITS-1:0]     rd_addr,
    input  logic [RD_PORTS*ABITS-1:0]     rd_addr_taint,
    output logic [RD_PORTS*WIDTH-1:0]     rd_data_taint,
    input  logic [WR_PORTS*WIDTH-1:0]     wr_en,
    input  logic [WR_PORTS*WIDTH-1:0]     wr_en_taint,
    input  logic [WR_PORTS*ABITS-1:0]     wr_addr,
    input  logic [WR_PORTS*ABITS-1:0]     wr_addr_taint,
    input  logic [WR_PORTS*WIDTH-1:0]     wr_data_taint,
    input  logic                          clr_req,
    output logic                          clr_busy,
    output logic [ABITS:0]                taint_sum
);
    import pift_pkg::*;

    // Array spans the full address space so every ABITS index is legal;
    // words at or beyond SIZE are never written.
    localparam int c_depth = 1 << ABITS;

    logic [WIDTH-1:0] r_mem     [c_depth];
    logic [WIDTH-1:0] w_mem_nxt [c_depth];
    logic [WIDTH-1:0] w_wr_mask [c_depth];
    logic             w_clr_stb;
    logic [ABITS-1:0] w_clr_idx;

    taintcell_memx_sweep #(
        .SIZE  (SIZE),
        .ABITS (ABITS)
    ) u_sweep (
        .pos_clk  (pos_clk),
        .pos_arst (pos_arst),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_stb  (w_clr_stb),
        .clr_idx  (w_clr_idx)
    );

    // Sweep clear first, then ports in ascending order so the highest port wins.
    always_comb begin
        logic [ABITS-1:0] v_idx;
        logic             v_addr_t;
        w_mem_nxt = r_mem;
        for (int w = 0; w < c_depth; w++) begin
            w_wr_mask[w] = '0;
        end
        v_idx    = '0;
        v_addr_t = 1'b0;
        if (w_clr_stb) begin
            w_mem_nxt[w_clr_idx] = '0;
        end
        for (int p = 0; p < WR_PORTS; p++) begin
            v_idx    = wr_addr[p*ABITS +: ABITS] - ABITS'(OFFSET);
            v_addr_t = |wr_addr_taint[p*ABITS +: ABITS];
            if (pift_addr_in_range(32'(wr_addr[p*ABITS +: ABITS]), 32'(OFFSET), 32'(SIZE))) begin
                for (int j = 0; j < WIDTH; j++) begin
                    if (wr_en[p*WIDTH+j]) begin
                        w_mem_nxt[v_idx][j] = wr_data_taint[p*WIDTH+j] | v_addr_t
                                            | wr_en_taint[p*WIDTH+j];
                        w_wr_mask[v_idx][j] = 1'b1;
                    end else if (wr_en_taint[p*WIDTH+j]) begin
                        w_mem_nxt[v_idx][j] = 1'b1;
                        w_wr_mask[v_idx][j] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge pos_clk or posedge pos_arst) begin
        if (pos_arst) begin
            for (int w = 0; w < c_depth; w++) begin
                r_mem[w] <= '0;
            end
        end else begin
            for (int w = 0; w < c_depth; w++) begin
                r_mem[w] <= w_mem_nxt[w];
            end
        end
    end

    for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
        localparam logic [WIDTH-1:0] c_tmask = {WIDTH{RD_TRANSPARENT[i]}};

        logic [ABITS-1:0] w_idx;
        logic             w_in_range;
        logic [WIDTH-1:0] w_bypass;
        logic [WIDTH-1:0] w_word;
        logic [WIDTH-1:0] w_nxt;
        logic [WIDTH-1:0] r_data;

        assign w_idx      = rd_addr[i*ABITS +: ABITS] - ABITS'(OFFSET);
        assign w_in_range = pift_addr_in_range(32'(rd_addr[i*ABITS +: ABITS]), 32'(OFFSET), 32'(SIZE));
        assign w_bypass   = w_wr_mask[w_idx] & c_tmask;
        assign w_word     = (r_mem[w_idx] & ~w_bypass) | (w_mem_nxt[w_idx] & w_bypass);

        always_comb begin
            w_nxt = r_data;
            if (rd_en_taint[i] || (rd_en[i] && !w_in_range)) begin
                w_nxt = '1;
            end else if (rd_en[i]) begin
                w_nxt = w_word | {WIDTH{|rd_addr_taint[i*ABITS +: ABITS]}};
            end
        end

        always_ff @(posedge pos_clk or posedge pos_arst) begin
            if (pos_arst) begin
                r_data <= '0;
            end else begin
                r_data <= w_nxt;
            end
        end

        assign rd_data_taint[i*WIDTH +: WIDTH] = r_data;
    end

`ifdef PIFT_TAINT_SUM_EN
    localparam logic [ABITS:0] c_sum_one = (ABITS+1)'(1);

    logic [c_depth-1:0] w_touched;
    logic [ABITS:0]     w_up;
    logic [ABITS:0]     w_dn;
    logic [ABITS:0]     r_sum;

    // Only swept or written words can change their tainted/clean status.
    always_comb begin
        w_up = '0;
        w_dn = '0;
        for (int w = 0; w < c_depth; w++) begin
            w_touched[w] = (w_clr_stb && (w_clr_idx == ABITS'(w))) || (|w_wr_mask[w]);
            if (w_touched[w]) begin
                if (!(|r_mem[w]) && (|w_mem_nxt[w])) begin
                    w_up = w_up + c_sum_one;
                end else if ((|r_mem[w]) && !(|w_mem_nxt[w])) begin
                    w_dn = w_dn + c_sum_one;
                end
            end
        end
    end

    always_ff @(posedge pos_clk or posedge pos_arst) begin
        if (pos_arst) begin
            r_sum <= '0;
        end else begin
            r_sum <= r_sum + w_up - w_dn;
        end
    end

    assign taint_sum = r_sum;
`else
    assign taint_sum = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_taintcell_memx.sv
// ============================================================================
// Module   : tb_taintcell_memx
// Brief    : Directed self-checking bench for taintcell_memx (2R/2W, port 1 transparent).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_taintcell_memx;

    logic        pos_clk = 1'b0;
    logic        pos_arst;
    logic [1:0]  rd_en;
    logic [1:0]  rd_en_taint;
    logic [5:0]  rd_addr;
    logic [5:0]  rd_addr_taint;
    logic [15:0] rd_data_taint;
    logic [15:0] wr_en;
    logic [15:0] wr_en_taint;
    logic [5:0]  wr_addr;
    logic [5:0]  wr_addr_taint;
    logic [15:0] wr_data_taint;
    logic        clr_req;
    logic        clr_busy;
    logic [3:0]  taint_sum;

    int n_total = 0;
    int n_bad   = 0;

    taintcell_memx #(
        .SIZE           (4),
        .OFFSET         (0),
        .ABITS          (3),
        .WIDTH          (8),
        .RD_PORTS       (2),
        .WR_PORTS       (2),
        .RD_TRANSPARENT (2'b10)
    ) dut (
        .pos_clk       (pos_clk),
        .pos_arst      (pos_arst),
        .rd_en         (rd_en),
        .rd_en_taint   (rd_en_taint),
        .rd_addr       (rd_addr),
        .rd_addr_taint (rd_addr_taint),
        .rd_data_taint (rd_data_taint),
        .wr_en         (wr_en),
        .wr_en_taint   (wr_en_taint),
        .wr_addr       (wr_addr),
        .wr_addr_taint (wr_addr_taint),
        .wr_data_taint (wr_data_taint),
        .clr_req       (clr_req),
        .clr_busy      (clr_busy),
        .taint_sum     (taint_sum)
    );

    always #5 pos_clk = ~pos_clk;

    function automatic logic [3:0] es(input int v);
`ifdef PIFT_TAINT_SUM_EN
        return 4'(v);
`else
        return 4'(v * 0);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pos_clk);
        #1;
    endtask

    task automatic quiet();
        rd_en = '0; rd_en_taint = '0; rd_addr = '0; rd_addr_taint = '0;
        wr_en = '0; wr_en_taint = '0; wr_addr = '0; wr_addr_taint = '0;
        wr_data_taint = '0; clr_req = 1'b0;
    endtask

    task automatic wr(input int p, input logic [2:0] a, input logic [7:0] en,
                      input logic [7:0] ent, input logic [7:0] dat);
        wr_en[p*8 +: 8]         = en;
        wr_en_taint[p*8 +: 8]   = ent;
        wr_addr[p*3 +: 3]       = a;
        wr_data_taint[p*8 +: 8] = dat;
    endtask

    task automatic rd(input int i, input logic [2:0] a);
        rd_en[i]          = 1'b1;
        rd_addr[i*3 +: 3] = a;
    endtask

    initial begin
        pos_arst = 1'b1;
        quiet();
        tick(); tick();
        chk("rst_rd", rd_data_taint, 16'h0000);
        chk("rst_busy", clr_busy, 1'b0);
        chk("rst_sum", taint_sum, 4'd0);
        pos_arst = 1'b0;

        // Full write, then read back
        wr(0, 3'd1, 8'hFF, 8'h00, 8'h0F);
        tick();
        chk("wr1_sum", taint_sum, es(1));
        quiet(); rd(0, 3'd1);
        tick();
        chk("rd1", rd_data_taint[7:0], 8'h0F);

        // Tainted-but-deasserted enables
        quiet(); wr(0, 3'd2, 8'h00, 8'h81, 8'h00);
        tick();
        chk("ent_sum", taint_sum, es(2));
        quiet(); rd(0, 3'd2); rd(1, 3'd1);
        tick();
        chk("ent_rd0", rd_data_taint[7:0], 8'h81);
        chk("ent_rd1", rd_data_taint[15:8], 8'h0F);

        // Clean write plus tainted read address; out-of-range read
        quiet(); wr(0, 3'd1, 8'hFF, 8'h00, 8'h00); rd(0, 3'd1); rd_addr_taint[2:0] = 3'b001; rd(1, 3'd4);
        tick();
        chk("addrt_rd0", rd_data_taint[7:0], 8'hFF);
        chk("oor_rd1", rd_data_taint[15:8], 8'hFF);
        chk("clean_sum", taint_sum, es(1));
        quiet(); rd(0, 3'd1);
        tick();
        chk("clean_rd0", rd_data_taint[7:0], 8'h00);

        // Hold with rd_en low
        quiet(); rd_addr[5:3] = 3'd2;
        tick();
        chk("hold_rd1", rd_data_taint[15:8], 8'hFF);

        // Tainted read enable
        quiet(); rd_en_taint[0] = 1'b1; rd_addr[2:0] = 3'd1;
        tick();
        chk("ent_rd", rd_data_taint[7:0], 8'hFF);

        // Same-cycle write/read: port 0 plain, port 1 transparent
        quiet(); wr(0, 3'd3, 8'hFF, 8'h00, 8'h3C); rd(0, 3'd3); rd(1, 3'd3);
        tick();
        chk("plain_rd0", rd_data_taint[7:0], 8'h00);
        chk("transp_rd1", rd_data_taint[15:8], 8'h3C);
        chk("w3_sum", taint_sum, es(2));
        quiet(); rd(0, 3'd3);
        tick();
        chk("w3_rd0", rd_data_taint[7:0], 8'h3C);

        // Two ports on the same word: port 1 wins
        quiet(); wr(0, 3'd0, 8'hFF, 8'h00, 8'hAA); wr(1, 3'd0, 8'hFF, 8'h00, 8'h55);
        tick();
        chk("prio_sum", taint_sum, es(3));
        quiet(); rd(0, 3'd0);
        tick();
        chk("prio_rd0", rd_data_taint[7:0], 8'h55);

        // Out-of-range write is dropped
        quiet(); wr(0, 3'd5, 8'hFF, 8'h00, 8'hFF);
        tick();
        chk("oorw_sum", taint_sum, es(3));

        // Tainted write address on a single bit; port 1 sees only that bit bypassed
        quiet(); wr(0, 3'd1, 8'h01, 8'h00, 8'h00); wr_addr_taint[2:0] = 3'b001; rd(0, 3'd1); rd(1, 3'd1);
        tick();
        chk("wat_rd0", rd_data_taint[7:0], 8'h00);
        chk("wat_rd1", rd_data_taint[15:8], 8'h01);
        chk("wat_sum", taint_sum, es(4));

        // Sweep with a write landing on the word being swept
        quiet(); clr_req = 1'b1;
        tick();
        chk("sw0_busy", clr_busy, 1'b1);
        chk("sw0_sum", taint_sum, es(4));
        quiet();
        tick();
        chk("sw1_busy", clr_busy, 1'b1);
        chk("sw1_sum", taint_sum, es(3));
        quiet(); clr_req = 1'b1;
        tick();
        chk("sw2_busy", clr_busy, 1'b1);
        chk("sw2_sum", taint_sum, es(2));
        quiet(); wr(0, 3'd2, 8'hFF, 8'h00, 8'h01);
        tick();
        chk("sw3_busy", clr_busy, 1'b1);
        chk("sw3_sum", taint_sum, es(2));
        quiet();
        tick();
        chk("sw4_busy", clr_busy, 1'b0);
        chk("sw4_sum", taint_sum, es(1));
        quiet();
        tick();
        chk("sw5_busy", clr_busy, 1'b0);
        quiet(); rd(0, 3'd2); rd(1, 3'd3);
        tick();
        chk("sw_rd2", rd_data_taint[7:0], 8'h01);
        chk("sw_rd3", rd_data_taint[15:8], 8'h00);
        quiet(); rd(0, 3'd0); rd(1, 3'd1);
        tick();
        chk("sw_rd0", rd_data_taint[7:0], 8'h00);
        chk("sw_rd1", rd_data_taint[15:8], 8'h00);

        // Reset in the middle of a sweep
        quiet(); wr(0, 3'd0, 8'hFF, 8'h00, 8'hFF); wr(1, 3'd1, 8'hFF, 8'h00, 8'hFF);
        tick();
        chk("pre_sum", taint_sum, es(3));
        quiet(); rd(0, 3'd0);
        tick();
        chk("pre_rd0", rd_data_taint[7:0], 8'hFF);
        quiet(); clr_req = 1'b1;
        tick();
        chk("ar0_busy", clr_busy, 1'b1);
        quiet();
        tick();
        chk("ar1_sum", taint_sum, es(2));
        pos_arst = 1'b1;
        #1;
        chk("ar_busy", clr_busy, 1'b0);
        chk("ar_sum", taint_sum, 4'd0);
        chk("ar_rd", rd_data_taint, 16'h0000);
        #2;
        pos_arst = 1'b0;
        quiet(); rd(0, 3'd1); rd(1, 3'd2);
        tick();
        chk("post_rd1", rd_data_taint[7:0], 8'h00);
        chk("post_rd2", rd_data_taint[15:8], 8'h00);
        quiet(); rd(0, 3'd0); rd(1, 3'd3);
        tick();
        chk("post_rd0", rd_data_taint[7:0], 8'h00);
        chk("post_rd3", rd_data_taint[15:8], 8'h00);
        chk("post_busy", clr_busy, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
